// File: rtl/udp_tx_framer.sv
// udp_tx_framer: streams one Ethernet II / IPv4 / UDP frame (no FCS) as 16-bit words for the
// DM9000A transmit writer, with the IPv4 header checksum built at run time and minimum-length padding.
module udp_tx_framer #(
    parameter logic [47:0] MAC_DST      = 48'h28d2444fd6ac,
    parameter logic [47:0] MAC_SRC      = 48'h123456789ABC,
    parameter logic [31:0] IP_SRC       = 32'hC0A8012C,
    parameter logic [31:0] IP_DST       = 32'hC0A80101,
    parameter logic [15:0] UDP_SRC_PORT = 16'd8000,
    parameter logic [15:0] UDP_DST_PORT = 16'd8000,
    parameter int          MAX_PAYLOAD  = 1472
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] payload_len,
    input  logic [15:0] pl_data,
    input  logic        pl_valid,
    output logic        pl_ready,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_last,
    output logic [15:0] frame_len,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CSUM    = 3'd1;
    localparam logic [2:0] S_HDR     = 3'd2;
    localparam logic [2:0] S_PAYLOAD = 3'd3;
    localparam logic [2:0] S_PAD     = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic [15:0] MAX_LEN       = 16'(MAX_PAYLOAD);
    localparam logic [15:0] LAST_HDR_WORD = 16'd20;

    logic [2:0]  r_state;
    logic [15:0] r_len;
    logic [15:0] r_ipId;
    logic [31:0] r_sum;
    logic [15:0] r_csum;
    logic [15:0] r_frameLen;
    logic [15:0] r_totalWords;
    logic [15:0] r_plWords;
    logic [15:0] r_wordIdx;
    logic        r_csumPhase;
    logic        r_err;

    logic [15:0] w_totLen;
    logic [15:0] w_udpLen;
    logic [31:0] w_sumCalc;
    logic [16:0] w_fold1;
    logic [15:0] w_fold2;
    logic [15:0] w_startFrameLen;
    logic [15:0] w_startTotalWords;
    logic [15:0] w_startPlWords;
    logic [15:0] w_hdrWord;
    logic        w_xfer;
    logic        w_lastWord;
    logic        w_lastPl;

    assign w_totLen = r_len + 16'd28;
    assign w_udpLen = r_len + 16'd8;

    assign w_sumCalc = 32'h0000_4500 + {16'h0000, w_totLen} + {16'h0000, r_ipId}
                     + 32'h0000_4000 + 32'h0000_4011
                     + {16'h0000, IP_SRC[31:16]} + {16'h0000, IP_SRC[15:0]}
                     + {16'h0000, IP_DST[31:16]} + {16'h0000, IP_DST[15:0]};

    // Two end-around-carry folds are enough for a sum of ten 16-bit terms.
    assign w_fold1 = {1'b0, r_sum[15:0]} + {1'b0, r_sum[31:16]};
    assign w_fold2 = w_fold1[15:0] + {15'b0, w_fold1[16]};

    assign w_startFrameLen   = (payload_len > 16'd18) ? payload_len + 16'd42 : 16'd60;
    assign w_startTotalWords = {1'b0, w_startFrameLen[15:1]} + {15'b0, w_startFrameLen[0]};
    assign w_startPlWords    = {1'b0, payload_len[15:1]} + {15'b0, payload_len[0]};

    assign w_xfer     = tx_valid & tx_ready;
    assign w_lastWord = (r_wordIdx == r_totalWords - 16'd1);
    assign w_lastPl   = (r_wordIdx == r_plWords + LAST_HDR_WORD);

    // Header words in network (big-endian) order; the byte swap happens on the output mux.
    always_comb begin
        w_hdrWord = 16'h0000;
        case (r_wordIdx)
            16'd0:   w_hdrWord = MAC_DST[47:32];
            16'd1:   w_hdrWord = MAC_DST[31:16];
            16'd2:   w_hdrWord = MAC_DST[15:0];
            16'd3:   w_hdrWord = MAC_SRC[47:32];
            16'd4:   w_hdrWord = MAC_SRC[31:16];
            16'd5:   w_hdrWord = MAC_SRC[15:0];
            16'd6:   w_hdrWord = 16'h0800;
            16'd7:   w_hdrWord = 16'h4500;
            16'd8:   w_hdrWord = w_totLen;
            16'd9:   w_hdrWord = r_ipId;
            16'd10:  w_hdrWord = 16'h4000;
            16'd11:  w_hdrWord = 16'h4011;
            16'd12:  w_hdrWord = r_csum;
            16'd13:  w_hdrWord = IP_SRC[31:16];
            16'd14:  w_hdrWord = IP_SRC[15:0];
            16'd15:  w_hdrWord = IP_DST[31:16];
            16'd16:  w_hdrWord = IP_DST[15:0];
            16'd17:  w_hdrWord = UDP_SRC_PORT;
            16'd18:  w_hdrWord = UDP_DST_PORT;
            16'd19:  w_hdrWord = w_udpLen;
            default: w_hdrWord = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_len        <= 16'h0000;
            r_ipId       <= 16'h0000;
            r_sum        <= 32'h0000_0000;
            r_csum       <= 16'h0000;
            r_frameLen   <= 16'h0000;
            r_totalWords <= 16'h0000;
            r_plWords    <= 16'h0000;
            r_wordIdx    <= 16'h0000;
            r_csumPhase  <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (payload_len > MAX_LEN) begin
                            r_err <= 1'b1;
                        end else begin
                            r_len        <= payload_len;
                            r_frameLen   <= w_startFrameLen;
                            r_totalWords <= w_startTotalWords;
                            r_plWords    <= w_startPlWords;
                            r_wordIdx    <= 16'h0000;
                            r_csumPhase  <= 1'b0;
                            r_state      <= S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (!r_csumPhase) begin
                        r_sum       <= w_sumCalc;
                        r_csumPhase <= 1'b1;
                    end else begin
                        r_csum  <= ~w_fold2;
                        r_state <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (w_xfer) begin
                        r_wordIdx <= r_wordIdx + 16'd1;
                        if (r_wordIdx == LAST_HDR_WORD) begin
                            r_state <= (r_plWords != 16'h0000) ? S_PAYLOAD : S_PAD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (w_xfer) begin
                        r_wordIdx <= r_wordIdx + 16'd1;
                        if (w_lastPl) begin
                            r_state <= w_lastWord ? S_DONE : S_PAD;
                        end
                    end
                end
                S_PAD: begin
                    if (w_xfer) begin
                        r_wordIdx <= r_wordIdx + 16'd1;
                        if (w_lastWord) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_ipId  <= r_ipId + 16'd1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Payload words pass straight through; an odd length blanks the spare high byte.
    always_comb begin
        tx_data  = 16'h0000;
        tx_valid = 1'b0;
        pl_ready = 1'b0;
        case (r_state)
            S_HDR: begin
                tx_valid = 1'b1;
                tx_data  = {w_hdrWord[7:0], w_hdrWord[15:8]};
            end
            S_PAYLOAD: begin
                tx_valid = pl_valid;
                pl_ready = tx_ready;
                if (r_len[0] && w_lastPl) begin
                    tx_data = {8'h00, pl_data[7:0]};
                end else begin
                    tx_data = pl_data;
                end
            end
            S_PAD: begin
                tx_valid = 1'b1;
            end
            default: begin
                tx_valid = 1'b0;
            end
        endcase
    end

    assign tx_last   = tx_valid & w_lastWord;
    assign frame_len = r_frameLen;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign err       = r_err;

endmodule
